// File: rtl/gerenciador_memorias_multicanal_pkg.sv
// Shared widths and helpers for the multichannel node-memory manager.
package gerenciador_pkg;

    localparam int DEF_ADDR_WIDTH          = 8;
    localparam int DEF_RELACOES_DATA_WIDTH = 8;

    // A single channel still needs a one-bit tag.
    function automatic int canal_width(input int num_canais);
        return (num_canais <= 1) ? 1 : $clog2(num_canais);
    endfunction

    function automatic int addr_lsb(input int canal, input int addr_width);
        return canal * addr_width;
    endfunction

endpackage

// File: rtl/gerenciador_memorias_multicanal_arbitro.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module arbitro_round_robin
    import gerenciador_pkg::*;
#(
    parameter int NUM_CANAIS  = 4,
    parameter int CANAL_WIDTH = canal_width(NUM_CANAIS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [NUM_CANAIS-1:0]  i_req,
    output logic [NUM_CANAIS-1:0]  o_gnt,
    output logic [CANAL_WIDTH-1:0] o_idx,
    output logic                   o_gnt_vld
);

    logic [CANAL_WIDTH-1:0] r_ptr;

    // First pass searches from the pointer upward, second pass covers the wrap.
    always_comb begin
        o_gnt     = '0;
        o_idx     = '0;
        o_gnt_vld = 1'b0;
        if (i_en) begin
            for (int i = 0; i < NUM_CANAIS; i++) begin
                if (!o_gnt_vld && (i >= int'(r_ptr)) && i_req[i]) begin
                    o_gnt[i]  = 1'b1;
                    o_idx     = CANAL_WIDTH'(i);
                    o_gnt_vld = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CANAIS; i++) begin
                if (!o_gnt_vld && i_req[i]) begin
                    o_gnt[i]  = 1'b1;
                    o_idx     = CANAL_WIDTH'(i);
                    o_gnt_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (o_gnt_vld)
            r_ptr <= (o_idx == CANAL_WIDTH'(NUM_CANAIS - 1)) ? '0 : o_idx + CANAL_WIDTH'(1);
    end

endmodule

// File: rtl/gerenciador_memorias_multicanal_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module dual_port_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data_p1;

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            r_rd_data_p1 <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data_p1;

endmodule

// File: rtl/gerenciador_memorias_multicanal.sv
// Multichannel manager for the relations and obstacle memories with a host load port.
// Optional macro GERENCIADOR_WR_FORWARD_EN: same-address read-during-write returns the new data.
module gerenciador_memorias_multicanal
    import gerenciador_pkg::*;
#(
    parameter int ADDR_WIDTH          = DEF_ADDR_WIDTH,
    parameter int RELACOES_DATA_WIDTH = DEF_RELACOES_DATA_WIDTH,
    parameter int NUM_CANAIS          = 4,
    parameter int CANAL_WIDTH         = canal_width(NUM_CANAIS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CANAIS-1:0]            canal_req_in,
    input  logic [NUM_CANAIS*ADDR_WIDTH-1:0] canal_addr_in,
    output logic [NUM_CANAIS-1:0]            canal_gnt_out,
    output logic                             rd_valid_out,
    output logic [CANAL_WIDTH-1:0]           rd_canal_out,
    output logic [RELACOES_DATA_WIDTH-1:0]   rd_relacoes_out,
    output logic                             rd_obstaculo_out,
    input  logic                             carga_en_in,
    input  logic                             wr_en_in,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_in,
    input  logic [RELACOES_DATA_WIDTH-1:0]   wr_relacoes_in,
    input  logic                             wr_obstaculo_in,
    output logic                             ocupado_out
);

    logic                           w_arb_en;
    logic [NUM_CANAIS-1:0]          w_gnt;
    logic [CANAL_WIDTH-1:0]         w_idx;
    logic                           w_gnt_vld;
    logic [ADDR_WIDTH-1:0]          w_rd_addr;
    logic [RELACOES_DATA_WIDTH-1:0] w_ram_rel;
    logic [0:0]                     w_ram_obs;
    logic [RELACOES_DATA_WIDTH-1:0] w_rel_sel;
    logic                           w_obs_sel;

    logic                           r_vld_p1;
    logic [CANAL_WIDTH-1:0]         r_canal_p1;
    logic                           r_dado_ok_p1;

    // Grants are suppressed during load and while reset is asserted.
    assign w_arb_en = ~carga_en_in & rst_n;

    arbitro_round_robin #(
        .NUM_CANAIS  (NUM_CANAIS),
        .CANAL_WIDTH (CANAL_WIDTH)
    ) u_arbitro (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_arb_en),
        .i_req     (canal_req_in),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    assign canal_gnt_out = w_gnt;

    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < NUM_CANAIS; i++) begin
            if (w_gnt[i])
                w_rd_addr = canal_addr_in[addr_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
        end
    end

    // ---- stage p0 -> p1: registered RAM read ----
    dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (RELACOES_DATA_WIDTH)
    ) u_mem_relacoes (
        .clk       (clk),
        .i_wr_en   (wr_en_in),
        .i_wr_addr (wr_addr_in),
        .i_wr_data (wr_relacoes_in),
        .i_rd_en   (w_gnt_vld),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_rel)
    );

    dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (1)
    ) u_mem_obstaculo (
        .clk       (clk),
        .i_wr_en   (wr_en_in),
        .i_wr_addr (wr_addr_in),
        .i_wr_data (wr_obstaculo_in),
        .i_rd_en   (w_gnt_vld),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_obs)
    );

    // r_dado_ok_p1 masks the unreset RAM register until a read completes after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1     <= 1'b0;
            r_canal_p1   <= '0;
            r_dado_ok_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_canal_p1   <= w_idx;
                r_dado_ok_p1 <= 1'b1;
            end
        end
    end

`ifdef GERENCIADOR_WR_FORWARD_EN
    logic                           r_fwd_p1;
    logic [RELACOES_DATA_WIDTH-1:0] r_fwd_rel_p1;
    logic                           r_fwd_obs_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fwd_p1 <= 1'b0;
        else if (w_gnt_vld)
            r_fwd_p1 <= wr_en_in && (wr_addr_in == w_rd_addr);
    end

    always_ff @(posedge clk) begin
        if (w_gnt_vld) begin
            r_fwd_rel_p1 <= wr_relacoes_in;
            r_fwd_obs_p1 <= wr_obstaculo_in;
        end
    end

    assign w_rel_sel = r_fwd_p1 ? r_fwd_rel_p1 : w_ram_rel;
    assign w_obs_sel = r_fwd_p1 ? r_fwd_obs_p1 : w_ram_obs[0];
`else
    assign w_rel_sel = w_ram_rel;
    assign w_obs_sel = w_ram_obs[0];
`endif

    assign rd_valid_out     = r_vld_p1;
    assign rd_canal_out     = r_canal_p1;
    assign rd_relacoes_out  = r_dado_ok_p1 ? w_rel_sel : '0;
    assign rd_obstaculo_out = r_dado_ok_p1 ? w_obs_sel : 1'b0;
    assign ocupado_out      = carga_en_in | r_vld_p1;

endmodule

// File: tb/tb_gerenciador_memorias_multicanal.sv
// Directed plus randomized bench for gerenciador_memorias_multicanal against a behavioural model.
module tb_gerenciador_memorias_multicanal;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  canal_req_in;
    logic [31:0] canal_addr_in;
    logic [3:0]  canal_gnt_out;
    logic        rd_valid_out;
    logic [1:0]  rd_canal_out;
    logic [7:0]  rd_relacoes_out;
    logic        rd_obstaculo_out;
    logic        carga_en_in;
    logic        wr_en_in;
    logic [7:0]  wr_addr_in;
    logic [7:0]  wr_relacoes_in;
    logic        wr_obstaculo_in;
    logic        ocupado_out;

    always #5 clk = ~clk;

    gerenciador_memorias_multicanal dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .canal_req_in     (canal_req_in),
        .canal_addr_in    (canal_addr_in),
        .canal_gnt_out    (canal_gnt_out),
        .rd_valid_out     (rd_valid_out),
        .rd_canal_out     (rd_canal_out),
        .rd_relacoes_out  (rd_relacoes_out),
        .rd_obstaculo_out (rd_obstaculo_out),
        .carga_en_in      (carga_en_in),
        .wr_en_in         (wr_en_in),
        .wr_addr_in       (wr_addr_in),
        .wr_relacoes_in   (wr_relacoes_in),
        .wr_obstaculo_in  (wr_obstaculo_in),
        .ocupado_out      (ocupado_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: memory image, fair pointer, and the last returned read.
    logic [7:0] m_rel_mem [256];
    logic       m_obs_mem [256];
    int         m_ptr;
    logic       m_vld;
    int         m_canal;
    logic [7:0] m_rel;
    logic       m_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelo_reset();
        m_ptr   = 0;
        m_vld   = 1'b0;
        m_canal = 0;
        m_rel   = 8'h00;
        m_obs   = 1'b0;
    endtask

    // One clock cycle: called just after a rising edge, returns just after the next one.
    task automatic ciclo(input logic [3:0] req, input logic [31:0] addrs, input logic carga,
                         input logic wen, input logic [7:0] wa, input logic [7:0] wrel,
                         input logic wobs);
        int         k;
        int         c;
        logic [7:0] ra;
        logic [3:0] eg;
        canal_req_in    = req;
        canal_addr_in   = addrs;
        carga_en_in     = carga;
        wr_en_in        = wen;
        wr_addr_in      = wa;
        wr_relacoes_in  = wrel;
        wr_obstaculo_in = wobs;
        #2;
        k = -1;
        if (!carga) begin
            for (int off = 0; off < 4; off++) begin
                c = (m_ptr + off) % 4;
                if (k < 0 && req[c]) k = c;
            end
        end
        eg = (k >= 0) ? (4'b0001 << k) : 4'b0000;
        chk("gnt", {28'h0, canal_gnt_out}, {28'h0, eg});
        chk("ocupado", {31'h0, ocupado_out}, {31'h0, carga | m_vld});
        if (k >= 0) begin
            ra      = addrs[k*8 +: 8];
            m_vld   = 1'b1;
            m_canal = k;
            m_rel   = m_rel_mem[ra];
            m_obs   = m_obs_mem[ra];
`ifdef GERENCIADOR_WR_FORWARD_EN
            if (wen && wa == ra) begin
                m_rel = wrel;
                m_obs = wobs;
            end
`endif
            m_ptr = (k + 1) % 4;
        end else begin
            m_vld = 1'b0;
        end
        if (wen) begin
            m_rel_mem[wa] = wrel;
            m_obs_mem[wa] = wobs;
        end
        @(posedge clk);
        #1;
        chk("rd_valid", {31'h0, rd_valid_out}, {31'h0, m_vld});
        chk("rd_canal", {30'h0, rd_canal_out}, m_canal);
        chk("rd_relacoes", {24'h0, rd_relacoes_out}, {24'h0, m_rel});
        chk("rd_obstaculo", {31'h0, rd_obstaculo_out}, {31'h0, m_obs});
    endtask

    initial begin
        logic [7:0]  v;
        logic [31:0] ad;
        rst_n = 1'b0;
        canal_req_in = '0; canal_addr_in = '0; carga_en_in = 1'b0;
        wr_en_in = 1'b0; wr_addr_in = '0; wr_relacoes_in = '0; wr_obstaculo_in = 1'b0;
        modelo_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'h0, rd_valid_out}, 32'h0);
        chk("reset_canal", {30'h0, rd_canal_out}, 32'h0);
        chk("reset_relacoes", {24'h0, rd_relacoes_out}, 32'h0);
        chk("reset_obstaculo", {31'h0, rd_obstaculo_out}, 32'h0);
        chk("reset_gnt", {28'h0, canal_gnt_out}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load every address with random content while channel 0 requests.
        for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            ciclo(4'b0001, 32'h0, 1'b1, 1'b1, 8'(a), v, 1'($urandom));
        end
        ciclo(4'b0001, 32'h0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b1);
        chk("load_ocupado", {31'h0, ocupado_out}, 32'h1);
        ciclo(4'b0001, 32'h0, 1'b1, 1'b1, 8'h20, 8'h00, 1'b0);

        // Single read on channel 2.
        ciclo(4'b0100, 32'h0010_0000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("single_canal", {30'h0, rd_canal_out}, 32'h2);
        chk("single_relacoes", {24'h0, rd_relacoes_out}, 32'hA5);
        chk("single_obstaculo", {31'h0, rd_obstaculo_out}, 32'h1);

        // Pointer is 3: requests on 1 and 3 give 3 then 1.
        ciclo(4'b1010, 32'h0300_0100, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("wrap_first", {30'h0, rd_canal_out}, 32'h3);
        ciclo(4'b1010, 32'h0300_0100, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("wrap_second", {30'h0, rd_canal_out}, 32'h1);
        ciclo(4'b1000, 32'h0400_0000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Pointer back at 0: all four channels held for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            ad = $urandom;
            ciclo(4'b1111, ad, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            chk("fair_order", {30'h0, rd_canal_out}, i % 4);
            chk("fair_valid", {31'h0, rd_valid_out}, 32'h1);
        end

        // Same-address read and write.
        ciclo(4'b0001, 32'h0000_0020, 1'b0, 1'b1, 8'h20, 8'h3C, 1'b1);
`ifdef GERENCIADOR_WR_FORWARD_EN
        chk("collision_relacoes", {24'h0, rd_relacoes_out}, 32'h3C);
`else
        chk("collision_relacoes", {24'h0, rd_relacoes_out}, 32'h00);
`endif
        ciclo(4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("idle_hold", {24'h0, rd_relacoes_out}, 32'h00
`ifdef GERENCIADOR_WR_FORWARD_EN
            | 32'h3C
`endif
        );

        // Randomized traffic on a small address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            ad = {4'h0, 4'($urandom), 4'h0, 4'($urandom), 4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            ciclo(4'($urandom_range(0, 15)), ad, ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 15)), 8'($urandom),
                  1'($urandom));
        end

        // Reset in the cycle after a grant.
        ciclo(4'b0010, 32'h0000_1100, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("pre_reset_valid", {31'h0, rd_valid_out}, 32'h1);
        canal_req_in = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_valid", {31'h0, rd_valid_out}, 32'h0);
        chk("reset_mid_canal", {30'h0, rd_canal_out}, 32'h0);
        modelo_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_valid", {31'h0, rd_valid_out}, 32'h0);
        ciclo(4'b0000, 32'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        ciclo(4'b1111, 32'h0302_0100, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("post_reset_ptr", {30'h0, rd_canal_out}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
